// File: rtl/equiv_bist.sv
// equiv_bist: exhaustive 4-input equivalence sweep engine.
// Drives all 16 vectors, compares reference vs DUT, logs results.
module equiv_bist #(
    parameter int unsigned SETTLE       = 2,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] vec_out,
    input  logic       f_ref,
    input  logic       f_dut,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail_valid,
    output logic [3:0] fail_vec,
    output logic [4:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [3:0] RELOAD = 4'(SETTLE);
    // With no settle time each vector goes straight to sampling.
    localparam state_e FIRST = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    state_e     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] mis_q, mis_d;
    logic       fv_q, fv_d;
    logic [3:0] fvec_q, fvec_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       miss;
    logic [4:0] mis_next;

    assign miss     = (f_ref != f_dut);
    assign mis_next = mis_q + 5'(miss);

    // Next-state and result update logic.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        done_d  = done_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d   = 4'd0;
                    mis_d   = 5'd0;
                    fv_d    = 1'b0;
                    fvec_d  = 4'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = RELOAD;
                    state_d = FIRST;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                mis_d = mis_next;
                if (miss && !fv_q) begin
                    fv_d   = 1'b1;
                    fvec_d = vec_q;
                end
                if (vec_q == 4'hF || (miss && STOP_ON_FAIL)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (mis_next == 5'd0);
                end else begin
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = RELOAD;
                    state_d = FIRST;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset abandons any sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= 4'd0;
            cnt_q   <= 4'd0;
            mis_q   <= 5'd0;
            fv_q    <= 1'b0;
            fvec_q  <= 4'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy         = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done         = done_q;
    assign pass         = pass_q;
    assign vec_out      = vec_q;
    assign fail_valid   = fv_q;
    assign fail_vec     = fvec_q;
    assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_equiv_bist.sv
// tb_equiv_bist: scoreboard bench for equiv_bist.
// Three instances cover SETTLE=2, STOP_ON_FAIL=1 and SETTLE=0.
module tb_equiv_bist;

    typedef struct {
        logic [4:0] cnt;
        logic [3:0] fvec;
        logic       fvalid;
        logic       pass;
        logic [3:0] last;
        longint     at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [3];
    logic [3:0]  vec   [3];
    logic        fref  [3];
    logic        fdut  [3];
    logic        busy  [3];
    logic        done  [3];
    logic        pass  [3];
    logic        fvalid[3];
    logic [3:0]  fvec  [3];
    logic [4:0]  mcnt  [3];
    logic [15:0] tt    [3];
    logic [15:0] flt   [3];
    logic        pdone [3];

    exp_t   q[3][$];
    longint edges = 0;
    int     tests = 0;
    int     fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign fref[g] = tt[g][vec[g]];
        assign fdut[g] = tt[g][vec[g]] ^ flt[g][vec[g]];
        equiv_bist #(
            .SETTLE      ((g == 2) ? 0 : 2),
            .STOP_ON_FAIL(g == 1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start[g]),
            .vec_out     (vec[g]),
            .f_ref       (fref[g]),
            .f_dut       (fdut[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .pass        (pass[g]),
            .fail_valid  (fvalid[g]),
            .fail_vec    (fvec[g]),
            .mismatch_cnt(mcnt[g])
        );
    end

    function automatic int settle_of(int g);
        return (g == 2) ? 0 : 2;
    endfunction

    function automatic bit stop_of(int g);
        return (g == 1);
    endfunction

    // Reference: walk the 16 vectors, a mask bit marks a differing output.
    function automatic exp_t model(int g, logic [15:0] m, longint s);
        exp_t e;
        int   n;
        e.cnt    = 5'd0;
        e.fvec   = 4'd0;
        e.fvalid = 1'b0;
        e.last   = 4'd0;
        n        = 0;
        for (int v = 0; v < 16; v++) begin
            n      = v + 1;
            e.last = v[3:0];
            if (m[v]) begin
                e.cnt = e.cnt + 5'd1;
                if (!e.fvalid) begin
                    e.fvalid = 1'b1;
                    e.fvec   = v[3:0];
                end
                if (stop_of(g)) break;
            end
        end
        e.pass = (e.cnt == 5'd0);
        e.at   = s + 1 + n * (settle_of(g) + 1);
        return e;
    endfunction

    task automatic chk(string n, int g, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0d expected %0d", n, g, act, exp);
        end
    endtask

    task automatic chk_zero(string tag);
        for (int g = 0; g < 3; g++) begin
            chk({tag, "_vec"}, g, vec[g], 0);
            chk({tag, "_busy"}, g, busy[g], 0);
            chk({tag, "_done"}, g, done[g], 0);
            chk({tag, "_pass"}, g, pass[g], 0);
            chk({tag, "_fvalid"}, g, fvalid[g], 0);
            chk({tag, "_fvec"}, g, fvec[g], 0);
            chk({tag, "_cnt"}, g, mcnt[g], 0);
        end
    endtask

    // Monitor: pop the expected result whenever done rises.
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (rst_n === 1'b1) begin
                chk("busy_and_done", g, busy[g] & done[g], 0);
                if (done[g] && !pdone[g]) begin
                    if (q[g].size() == 0) begin
                        chk("unexpected_done", g, 1, 0);
                    end else begin
                        e = q[g].pop_front();
                        chk("done_edge", g, edges, e.at);
                        chk("mismatch_cnt", g, mcnt[g], e.cnt);
                        chk("fail_vec", g, fvec[g], e.fvec);
                        chk("fail_valid", g, fvalid[g], e.fvalid);
                        chk("pass", g, pass[g], e.pass);
                        chk("last_vec", g, vec[g], e.last);
                        chk("busy_at_done", g, busy[g], 0);
                    end
                end
            end
            pdone[g] = done[g];
        end
    end

    task automatic sweep(int g, logic [15:0] m, bit pulses);
        longint s;
        int     k;
        int     lim;
        @(negedge clk);
        tt[g]    = 16'($urandom);
        flt[g]   = m;
        start[g] = 1'b1;
        s        = edges;
        q[g].push_back(model(g, m, s));
        @(negedge clk);
        start[g] = 1'b0;
        chk("clr_cnt", g, mcnt[g], 0);
        chk("clr_fvalid", g, fvalid[g], 0);
        chk("clr_fvec", g, fvec[g], 0);
        chk("clr_done", g, done[g], 0);
        chk("clr_busy", g, busy[g], 1);
        chk("clr_vec", g, vec[g], 0);
        lim = 16 * (settle_of(g) + 1) + 8;
        k   = 0;
        while (!done[g] && k < lim) begin
            if (pulses)
                start[g] = (edges == s + 10) || (edges == s + 30);
            if (settle_of(g) == 0)
                chk("vec_step", g, vec[g], edges - s - 1);
            @(negedge clk);
            k++;
        end
        start[g] = 1'b0;
        if (!done[g]) begin
            chk("done_timeout", g, 0, 1);
            q[g].delete();
        end
    endtask

    task automatic reset_mid();
        longint s;
        @(negedge clk);
        tt[0]    = 16'($urandom);
        flt[0]   = 16'hFFFF;
        start[0] = 1'b1;
        s        = edges;
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (edges >= s + 21) break;
            @(negedge clk);
        end
        chk("pre_reset_busy", 0, busy[0], 1);
        #2;
        start[0] = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        start[0] = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b1;
            tt[g]    = 16'h0;
            flt[g]   = 16'h0;
            pdone[g] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst_hold");
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        sweep(0, 16'h0000, 1'b0);
        sweep(0, 16'h0400, 1'b0);
        sweep(0, 16'hFFFF, 1'b0);
        sweep(1, 16'hFFFF, 1'b0);
        sweep(1, 16'($urandom), 1'b0);
        sweep(1, 16'h0000, 1'b0);
        reset_mid();
        sweep(0, 16'h0000, 1'b0);
        sweep(0, 16'h0000, 1'b1);
        sweep(2, 16'h0000, 1'b0);
        sweep(2, 16'($urandom), 1'b0);
        for (int i = 0; i < 6; i++)
            sweep(i % 3, 16'($urandom) & 16'($urandom), 1'b0);

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++)
            chk("queue_empty", g, q[g].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/equiv_bist.md
# equiv_bist

Synthesizable equivalence-check engine for 4-input single-output combinational blocks. It sweeps all 16 input vectors onto a reference implementation and an implementation under test, then compares their outputs. It records the mismatch count and the first failing vector, and reports pass/fail. It sits on the response side of the `figure1` / `figure1_beh` pair and replaces the simulation-only compare bench with hardware that runs on silicon or in emulation.

## Interface
Parameters:
- SETTLE, default 2: idle cycles each vector is held before sampling; range 0–15.
- STOP_ON_FAIL, default 0: when 1, the sweep ends at the first mismatch.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a sweep; sampled only in IDLE or DONE.
- vec_out  out  4  applied vector, {D,C,B,A} = [3:0]; A is the LSB and toggles fastest.
- f_ref  in  1  reference output (`figure1_beh` F).
- f_dut  in  1  implementation output (`figure1` F).
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; results valid.
- pass  out  1  done and mismatch_cnt == 0.
- fail_valid  out  1  at least one mismatch recorded.
- fail_vec  out  4  first vector that mismatched.
- mismatch_cnt  out  5  number of mismatching vectors, 0–16.

## Operation
States:
- IDLE: on start, go to SETTLE.
- SETTLE: counts down SETTLE cycles, then goes to CHECK.
- CHECK: samples the outputs, then goes to SETTLE (next vector) or DONE.
- DONE: on start, go to SETTLE.

Start of a sweep:
- In IDLE or DONE with start=1: vec_out←0, mismatch_cnt←0, fail_valid←0, fail_vec←0, done←0, pass←0, busy←1, settle counter←SETTLE.
- Next state is SETTLE. If SETTLE=0, next state is CHECK directly.
- start is ignored while busy.

SETTLE:
- Decrement the counter each cycle.
- Move to CHECK on the edge where the counter reaches 0.
- vec_out is stable throughout SETTLE and CHECK.

CHECK (one cycle):
- Compare f_ref against f_dut at the closing edge, using inequality.
- On mismatch: increment mismatch_cnt. If fail_valid=0, set fail_valid←1 and fail_vec←vec_out.
- If vec_out==15, or a mismatch occurred with STOP_ON_FAIL=1: go to DONE. busy←0, done←1, pass←(final mismatch_cnt==0).
- Otherwise: vec_out←vec_out+1, reload the counter, go to SETTLE (or CHECK when SETTLE=0).

DONE:
- vec_out holds the last vector; all results hold until start or reset.

Width and boundary rules:
- vec_out never wraps during a sweep.
- mismatch_cnt is 5 bits so it reaches 16 without overflow.
- pass is computed from the count including the final vector's result.

## Timing
- Reset (async assert, sync release): state IDLE, vec_out=0, busy=0, done=0, pass=0, fail_valid=0, fail_vec=0, mismatch_cnt=0.
- Reset mid-sweep aborts immediately to these values; no partial results are retained.
- Edge 0 is the edge that samples start=1.
- Vector k is driven after edge k·(SETTLE+1) and sampled at edge (k+1)·(SETTLE+1).
- Full sweep: done=1 and busy=0 after edge 16·(SETTLE+1). That is edge 48 for SETTLE=2 and edge 16 for SETTLE=0.
- With STOP_ON_FAIL=1 and first mismatch at vector k: done after edge (k+1)·(SETTLE+1).
- done and busy are never both 1; the busy→done transition occurs on the same edge.
- start=1 in DONE restarts on that edge: done drops and all results clear together.

## Test plan
- Reset: assert rst_n=0 mid-cycle with start=1 → all outputs 0 at once; stay in IDLE while held.
- Equivalent pair (f_dut = f_ref = some fixed function of vec_out), SETTLE=2, start at edge 0 → done=1 after edge 48, pass=1, mismatch_cnt=0, fail_valid=0.
- Single fault (f_dut inverted only at vec 4'b1010), SETTLE=2 → done after edge 48, mismatch_cnt=1, fail_vec=4'b1010, fail_valid=1, pass=0.
- Full inversion (f_dut = ~f_ref):
  - STOP_ON_FAIL=0 → mismatch_cnt=16, fail_vec=0.
  - STOP_ON_FAIL=1, SETTLE=2 → done after edge 3, mismatch_cnt=1, vec_out=0.
- Reset at edge 20 of a failing sweep, release, start again with an equivalent pair → no leftover count; pass=1 after 48 further edges.
- Control and boundary cases:
  - start pulsed at edges 10 and 30 while busy → no effect; done still after edge 48.
  - start in DONE → results clear on that edge and a new sweep runs.
  - SETTLE=0 with an equivalent pair → vec_out increments every cycle; done after edge 16.
